// File: rtl/traffic_pkg.sv
// Shared types and default phase durations for the intersection controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10
    } state_t;

    localparam int DEF_NUM_DIR     = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_GREEN_TIME  = 20;
    localparam int DEF_YELLOW_TIME = 3;
    localparam int DEF_ALLRED_TIME = 2;
    localparam int DEF_WALK_TIME   = 8;

    // A duration must be loadable as (duration-1) into a cnt_w-bit timer.
    function automatic logic dur_bad(input int dur, input int cnt_w);
        return (dur <= 0) || (longint'(dur) >= (longint'(1) << cnt_w));
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_rr_next_dir.sv
// Round-robin picker: first demanding approach after phase_dir, wrapping modulo NUM_DIR.
module rr_next_dir #(
    parameter int NUM_DIR = 4,
    parameter int DIR_W   = $clog2(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] demand,
    input  logic [DIR_W-1:0]   phase_dir,
    output logic [DIR_W-1:0]   next_dir,
    output logic               found
);

    logic [DIR_W:0] cand_s;

    // Scan phase_dir+1 .. phase_dir+NUM_DIR; the last candidate is phase_dir itself.
    always_comb begin
        next_dir = '0;
        found    = 1'b0;
        cand_s   = '0;
        for (int k = 1; k <= NUM_DIR; k++) begin
            cand_s = {1'b0, phase_dir} + (DIR_W+1)'(k);
            if (cand_s >= (DIR_W+1)'(NUM_DIR)) begin
                cand_s = cand_s - (DIR_W+1)'(NUM_DIR);
            end else begin
                cand_s = cand_s;
            end
            if (!found && demand[cand_s[DIR_W-1:0]]) begin
                found    = 1'b1;
                next_dir = cand_s[DIR_W-1:0];
            end else begin
                found    = found;
            end
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Intersection signal controller: ALLRED -> GREEN (extendable) -> YELLOW -> ALLRED.
// Optional pedestrian walk support is built when PED_WALK_EN is defined.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR     = DEF_NUM_DIR,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GREEN_TIME  = DEF_GREEN_TIME,
    parameter int YELLOW_TIME = DEF_YELLOW_TIME,
    parameter int ALLRED_TIME = DEF_ALLRED_TIME,
    parameter int WALK_TIME   = DEF_WALK_TIME
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_DIR-1:0]         sensor,
`ifdef PED_WALK_EN
    input  logic [NUM_DIR-1:0]         ped_req,
    output logic [NUM_DIR-1:0]         walk,
`endif
    output logic [NUM_DIR-1:0]         red,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [NUM_DIR-1:0]         green,
    output logic [$clog2(NUM_DIR)-1:0] phase_dir
);

    localparam int DIR_W = $clog2(NUM_DIR);
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TIME - 1);
    localparam logic [DIR_W-1:0] DIR_RST   = DIR_W'(NUM_DIR - 1);

    if (NUM_DIR < 2 || NUM_DIR > 8) begin : g_bad_num_dir
        $error("traffic_intersection_ctrl: NUM_DIR must be in 2..8");
    end
    if (dur_bad(GREEN_TIME, CNT_W) || dur_bad(YELLOW_TIME, CNT_W) ||
        dur_bad(ALLRED_TIME, CNT_W) || dur_bad(WALK_TIME, CNT_W)) begin : g_bad_dur
        $error("traffic_intersection_ctrl: durations must be in 1..2**CNT_W-1");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic [NUM_DIR-1:0] demand_s, others_s, cur_onehot_s;
    logic [DIR_W-1:0]   next_dir_s;
    logic               found_s, green_entry_s, fresh_entry_s;

    assign cur_onehot_s = NUM_DIR'(1) << dir_q;
    assign others_s     = demand_s & ~cur_onehot_s;
    assign phase_dir    = dir_q;

    rr_next_dir #(.NUM_DIR(NUM_DIR), .DIR_W(DIR_W)) u_rr (
        .demand    (demand_s),
        .phase_dir (dir_q),
        .next_dir  (next_dir_s),
        .found     (found_s)
    );

    // Phase sequencing; demand only matters on the cycle the timer reaches 0.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        dir_d         = dir_q;
        green_entry_s = 1'b0;
        fresh_entry_s = 1'b0;
        if (timer_q != '0) begin
            timer_d = timer_q - CNT_W'(1);
        end else begin
            case (state_q)
                ST_ALLRED: begin
                    if (found_s) begin
                        state_d       = ST_GREEN;
                        dir_d         = next_dir_s;
                        timer_d       = GREEN_LD;
                        green_entry_s = 1'b1;
                        fresh_entry_s = 1'b1;
                    end else begin
                        timer_d = '0;
                    end
                end
                ST_GREEN: begin
                    if (others_s != '0) begin
                        state_d = ST_YELLOW;
                        timer_d = YELLOW_LD;
                    end else begin
                        timer_d       = GREEN_LD;
                        green_entry_s = 1'b1;
                    end
                end
                ST_YELLOW: begin
                    state_d = ST_ALLRED;
                    timer_d = ALLRED_LD;
                end
                default: begin
                    state_d = ST_ALLRED;
                    timer_d = ALLRED_LD;
                    dir_d   = DIR_RST;
                end
            endcase
        end
    end

    // Phase state, timer and granted direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ALLRED;
            timer_q <= ALLRED_LD;
            dir_q   <= DIR_RST;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
        end
    end

    // Lamp decode from registered state only.
    always_comb begin
        red    = '1;
        yellow = '0;
        green  = '0;
        case (state_q)
            ST_GREEN: begin
                green = cur_onehot_s;
                red   = ~cur_onehot_s;
            end
            ST_YELLOW: begin
                yellow = cur_onehot_s;
                red    = ~cur_onehot_s;
            end
            default: begin
                red = '1;
            end
        endcase
    end

`ifdef PED_WALK_EN
    localparam logic [CNT_W-1:0] WALK_LD = CNT_W'(min_int(WALK_TIME, GREEN_TIME));

    logic [NUM_DIR-1:0] ped_q, ped_d, ped_clr_s;
    logic [CNT_W-1:0]   walk_cnt_q, walk_cnt_d;

    assign demand_s = sensor | ped_q;

    // Sticky pedestrian latches, cleared when their approach (re)enters green.
    always_comb begin
        ped_clr_s = '0;
        if (green_entry_s) begin
            ped_clr_s = NUM_DIR'(1) << dir_d;
        end else begin
            ped_clr_s = '0;
        end
        ped_d = (ped_q & ~ped_clr_s) | ped_req;
        if (fresh_entry_s) begin
            walk_cnt_d = WALK_LD;
        end else if (walk_cnt_q != '0) begin
            walk_cnt_d = walk_cnt_q - CNT_W'(1);
        end else begin
            walk_cnt_d = walk_cnt_q;
        end
    end

    // Pedestrian latch and walk timer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_q      <= '0;
            walk_cnt_q <= '0;
        end else begin
            ped_q      <= ped_d;
            walk_cnt_q <= walk_cnt_d;
        end
    end

    // Walk lamp for the green approach while its walk window is open.
    always_comb begin
        if (state_q == ST_GREEN && walk_cnt_q != '0) begin
            walk = cur_onehot_s;
        end else begin
            walk = '0;
        end
    end
`else
    assign demand_s = sensor;
`endif

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Randomized bench against a cycle-level schedule model of the intersection controller.
module tb_traffic_intersection_ctrl;

    localparam int N  = 4;
    localparam int G  = 20;
    localparam int Y  = 3;
    localparam int A  = 2;
    localparam int W  = 8;
    localparam int K_RED = 0;
    localparam int K_GRN = 1;
    localparam int K_YEL = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sensor, red, yellow, green, ped_req;
    logic [1:0] phase_dir;
    logic [2:0] red3, yellow3, green3;
    logic [1:0] phase_dir3;
`ifdef PED_WALK_EN
    logic [3:0] walk;
    logic [2:0] walk3;
`endif

    int n_chk = 0;
    int n_err = 0;
    int m_kind, m_left, m_dir, m_walk, m_latch;
    int yel_seen, walk_seen;
    int order3 [4];
    int n_rec3 = 0;
    int bad3 = 0;
    logic [2:0] prev_g3 = 3'b000;

    always #5 clk = ~clk;

    traffic_intersection_ctrl dut (
        .clk(clk), .reset(reset), .sensor(sensor),
`ifdef PED_WALK_EN
        .ped_req(ped_req), .walk(walk),
`endif
        .red(red), .yellow(yellow), .green(green), .phase_dir(phase_dir)
    );

    traffic_intersection_ctrl #(.NUM_DIR(3)) dut3 (
        .clk(clk), .reset(reset), .sensor(3'b111),
`ifdef PED_WALK_EN
        .ped_req(3'b000), .walk(walk3),
`endif
        .red(red3), .yellow(yellow3), .green(green3), .phase_dir(phase_dir3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_kind  = K_RED;
        m_left  = A;
        m_dir   = N - 1;
        m_walk  = 0;
        m_latch = 0;
    endfunction

    // One clock of the schedule: m_left counts the cycles remaining in the phase.
    function automatic void model_step(input int sens, input int ped);
        int dem = sens | m_latch;
        int clr = 0;
        if (m_walk > 0) m_walk--;
        if (m_left > 1) begin
            m_left--;
        end else if (m_kind == K_RED) begin
            for (int k = 1; k <= N; k++) begin
                int d = (m_dir + k) % N;
                if (m_kind == K_RED && ((dem >> d) & 1) == 1) begin
                    m_kind = K_GRN; m_dir = d; m_left = G;
                    m_walk = (W < G) ? W : G;
                    clr = 1 << d;
                end
            end
        end else if (m_kind == K_GRN) begin
            if ((dem & ~(1 << m_dir)) != 0) begin
                m_kind = K_YEL; m_left = Y;
            end else begin
                m_left = G; clr = 1 << m_dir;
            end
        end else begin
            m_kind = K_RED; m_left = A;
        end
        m_latch = (m_latch & ~clr) | ped;
    endfunction

    task automatic check_outputs();
        int exp_r, exp_y, exp_g, r, y, g, nonred, lamp_ok;
        exp_r = (m_kind == K_RED) ? 'hF : ('hF & ~(1 << m_dir));
        exp_y = (m_kind == K_YEL) ? (1 << m_dir) : 0;
        exp_g = (m_kind == K_GRN) ? (1 << m_dir) : 0;
        chk("red", 32'(red), exp_r);
        chk("yellow", 32'(yellow), exp_y);
        chk("green", 32'(green), exp_g);
        chk("phase_dir", 32'(phase_dir), m_dir);
        r = int'(red); y = int'(yellow); g = int'(green);
        nonred = 0; lamp_ok = 1;
        for (int i = 0; i < N; i++) begin
            if (((r >> i) & 1) + ((y >> i) & 1) + ((g >> i) & 1) != 1) lamp_ok = 0;
            if (((r >> i) & 1) == 0) nonred++;
        end
        chk("one_lamp", lamp_ok, 1);
        chk("one_nonred", (nonred <= 1) ? 1 : 0, 1);
        if (yellow != 4'b0000) yel_seen = 1;
`ifdef PED_WALK_EN
        chk("walk", 32'(walk), (m_kind == K_GRN && m_walk > 0) ? (1 << m_dir) : 0);
        if (walk[2]) walk_seen++;
`endif
    endtask

    task automatic run(input int n, input bit rnd);
        for (int c = 0; c < n; c++) begin
            check_outputs();
            if (rnd) begin
                if ($urandom_range(0, 7) == 0) sensor = 4'($urandom);
`ifdef PED_WALK_EN
                ped_req = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
`endif
            end
            @(posedge clk);
            model_step(int'(sensor), int'(ped_req));
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Record the 3-approach instance's green order and range of phase_dir.
    always @(negedge clk) begin
        if (!reset) begin
            if (green3 != 3'b000 && prev_g3 == 3'b000 && n_rec3 < 4) begin
                order3[n_rec3] <= green3[1] ? 1 : (green3[2] ? 2 : 0);
                n_rec3 <= n_rec3 + 1;
            end
            if (phase_dir3 > 2'd2) bad3 <= 1;
            prev_g3 <= green3;
        end
    end

    initial begin
        reset   = 1'b1;
        sensor  = 4'b0101;
        ped_req = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // Fixed two-approach demand, cycle 0 = first cycle after release.
        for (int c = 0; c < 120; c++) begin
            check_outputs();
            case (c)
                1:  chk("c1_allred", 32'(red), 32'h0000_000F);
                2:  chk("c2_green0", 32'(green), 32'h0000_0001);
                21: chk("c21_green0", 32'(green), 32'h0000_0001);
                22: chk("c22_yellow0", 32'(yellow), 32'h0000_0001);
                24: chk("c24_yellow0", 32'(yellow), 32'h0000_0001);
                25: chk("c25_allred", 32'(red), 32'h0000_000F);
                26: chk("c26_allred", 32'(red), 32'h0000_000F);
                27: chk("c27_green2", 32'(green), 32'h0000_0004);
                default: ;
            endcase
            @(posedge clk);
            model_step(int'(sensor), int'(ped_req));
            @(negedge clk);
        end

        // No demand: all red indefinitely, then immediate grant.
        sensor = 4'b0000;
        do_reset();
        run(40, 1'b0);
        chk("idle_red", 32'(red), 32'h0000_000F);
        sensor = 4'b1000;
        run(1, 1'b0);
        chk("g3_next", 32'(green), 32'h0000_0008);

        // Single demand extends green without yellow.
        sensor = 4'b0010;
        do_reset();
        run(3, 1'b0);
        yel_seen = 0;
        run(60, 1'b0);
        chk("ext_no_yel", yel_seen, 0);
        chk("ext_green1", 32'(green), 32'h0000_0002);
        sensor = 4'b1010;
        run(60, 1'b0);

        // Asynchronous reset in the middle of yellow.
        sensor = 4'b0101;
        do_reset();
        for (int i = 0; i < 100 && m_kind != K_YEL; i++) run(1, 1'b0);
        chk("reach_yel", m_kind, K_YEL);
        #1 reset = 1'b1;
        #1;
        chk("rst_red", 32'(red), 32'h0000_000F);
        chk("rst_yellow", 32'(yellow), 0);
        chk("rst_green", 32'(green), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

`ifdef PED_WALK_EN
        sensor = 4'b0000;
        do_reset();
        ped_req = 4'b0100;
        run(1, 1'b0);
        ped_req = 4'b0000;
        walk_seen = 0;
        run(40, 1'b0);
        chk("walk_len", walk_seen, 8);
        chk("ped_g2_hold", 32'(green), 32'h0000_0004);
`endif

        run(2000, 1'b1);

        chk("n3_count", n_rec3, 4);
        chk("n3_order0", order3[0], 0);
        chk("n3_order1", order3[1], 1);
        chk("n3_order2", order3[2], 2);
        chk("n3_order3", order3[3], 0);
        chk("n3_dir_range", bad3, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 Parameter NUM_DIR, 4, number of approaches; legal range 2..8.
REQ-002 Parameter CNT_W, 8, phase timer width in bits.
REQ-003 Parameter GREEN_TIME, 20, green phase length in clk cycles.
REQ-004 Parameter YELLOW_TIME, 3, yellow phase length in clk cycles.
REQ-005 Parameter ALLRED_TIME, 2, all-red clearance length in clk cycles.
REQ-006 Parameter WALK_TIME, 8, walk signal length in clk cycles; used only with PED_WALK_EN.
REQ-007 Port clk  in  1  clock; the reset is reset, asynchronous, active-high, and the clock is clk.
REQ-008 Port reset  in  1  asynchronous active-high reset.
REQ-009 Port sensor  in  NUM_DIR  vehicle demand per approach, level-sensitive.
REQ-010 Port red  out  NUM_DIR  red lamp per approach.
REQ-011 Port yellow  out  NUM_DIR  yellow lamp per approach.
REQ-012 Port green  out  NUM_DIR  green lamp per approach.
REQ-013 Port phase_dir  out  $clog2(NUM_DIR)  index of the approach last granted green.

Function
REQ-014 The FSM SHALL have three states: ST_ALLRED, ST_GREEN and ST_YELLOW. Transitions SHALL be ALLRED->GREEN, GREEN->YELLOW or GREEN->GREEN (extension), and YELLOW->ALLRED.
REQ-015 On entry to a state, the timer SHALL load (duration-1). The timer SHALL decrement each cycle. The state SHALL be evaluated for exit on the cycle the timer equals 0, so each state lasts exactly its duration.
REQ-016 ALLRED exit: the next direction SHALL be the first index after phase_dir, wrapping modulo NUM_DIR, whose demand bit is set. If no demand bit is set, the FSM SHALL stay in ALLRED with the timer held at 0 and re-evaluate every cycle.
REQ-017 GREEN exit: if any other approach has demand, the FSM SHALL go to YELLOW. Otherwise the FSM SHALL re-enter GREEN for the same approach and reload GREEN_TIME-1.
REQ-018 Demand SHALL be sampled only on the exit-evaluation cycle. Demand changes at other times SHALL be ignored.
REQ-019 Lamps SHALL be decoded only from registered state and phase_dir, with no combinational path from inputs.
REQ-020 In GREEN, green[phase_dir]=1; in YELLOW, yellow[phase_dir]=1. All other approaches SHALL show red=1. In ALLRED, red SHALL be all ones.
REQ-021 Each approach SHALL have exactly one lamp bit set in every cycle, and at most one approach SHALL be non-red.
REQ-022 With NUM_DIR not a power of two, the wrap from NUM_DIR-1 SHALL go to 0, and phase_dir SHALL never exceed NUM_DIR-1.

Reset
REQ-023 Reset SHALL take effect immediately, including mid-phase: state=ST_ALLRED, timer=ALLRED_TIME-1, phase_dir=NUM_DIR-1, red=all ones, yellow=0, green=0, and all pedestrian latches cleared.
REQ-024 After reset deassertion, the first green SHALL go to the lowest-index demanding approach, no earlier than ALLRED_TIME cycles later.

Configuration
REQ-025 Macro PED_WALK_EN defined: ports ped_req (in, NUM_DIR) and walk (out, NUM_DIR) SHALL exist.
- A ped_req pulse SHALL set a sticky per-approach latch.
- The latch SHALL count as demand in REQ-016 and REQ-017.
- On entry to GREEN for approach i, latch i SHALL clear.
- walk[i] SHALL be 1 for the first min(WALK_TIME, GREEN_TIME) cycles of that green.
- walk SHALL reset to 0.
REQ-026 Macro PED_WALK_EN undefined: the ped_req and walk ports and all latch and walk logic SHALL be absent; demand SHALL equal sensor.

Structure
REQ-027 Package traffic_pkg SHALL hold:
- the typedef state_t as a 2-bit enum: ST_ALLRED=00, ST_GREEN=01, ST_YELLOW=10;
- default duration constants.
REQ-028 Sub-module rr_next_dir (combinational round-robin picker) SHALL take demand[NUM_DIR] and phase_dir, and return next_dir plus a found flag.
REQ-029 Elaboration SHALL fail if any duration is 0 or is at least 2**CNT_W, or if NUM_DIR is outside 2..8.

Verification
REQ-030 Defaults, sensor=4'b0101 constant, reset released at cycle 0:
- green[0] in cycles 2..21;
- yellow[0] in cycles 22..24;
- all red in cycles 25..26;
- green[2] from cycle 27.
REQ-031 sensor=4'b0010 only: green[1] SHALL persist past 20 cycles through extension, with no yellow. Raising sensor[3] SHALL give yellow[1] at the next expiry, then green[3].
REQ-032 sensor=0: the FSM SHALL stay in all-red indefinitely. Setting sensor[3] SHALL give green[3] on the following cycle.
REQ-033 NUM_DIR=3, sensor=3'b111: the green order SHALL be 0,1,2,0, and phase_dir SHALL never be 3.
REQ-034 Reset asserted mid-yellow: outputs SHALL be all red within the same cycle. Every cycle SHALL satisfy the one-lamp-per-approach check.
REQ-035 With PED_WALK_EN, sensor=0, and a one-cycle ped_req[2] pulse: green[2] SHALL follow, with walk[2] high for exactly 8 cycles. The latch SHALL then clear, with no repeat green.
